// File: rtl/jpeg_frame_extractor.sv
// jpeg_frame_extractor: captures one SOI..EOI JPEG frame from a byte stream and re-emits it paced for the word packer
module jpeg_frame_extractor #(
   parameter int FIFO_DEPTH      = 16,
   parameter int MAX_FRAME_BYTES = 65536,
   parameter int STALL_CYCLES    = 5
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        enable_in,
   input  logic        data_valid_in,
   input  logic [7:0]  byte_in,
   output logic        data_valid_out,
   output logic [7:0]  byte_out,
   output logic        complete_out,
   output logic        frame_done_out,
   output logic [16:0] frame_bytes_out,
   output logic        busy_out,
   output logic        error_out
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [17:0] MAX_CNT = 18'(MAX_FRAME_BYTES);
   localparam logic [7:0] STALL = 8'(STALL_CYCLES);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
   typedef enum logic [1:0] {HUNT, FRAME, EOI} state_t;
   state_t state, state_nxt;
   logic [7:0] held;
   logic held_v;
   logic [17:0] byte_cnt, push_cnt;
   logic [16:0] pend_cnt;
   logic [8:0] mem [FIFO_DEPTH];
   logic [8:0] head, push_data;
   logic [AW:0] wr_ptr, rd_ptr;
   logic [7:0] stall_cnt;
   logic [1:0] out_idx;
   logic want, push, pop, full, empty, abort, soi;
   assign empty = wr_ptr == rd_ptr;
   assign full = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
   assign pop = !empty && stall_cnt == 8'd0;
   assign head = mem[rd_ptr[AW-1:0]];
   assign soi = held_v && held == 8'hFF && byte_in == 8'hD8;
   assign busy_out = state != HUNT || !empty || stall_cnt != 8'd0;
   always_comb begin
      want = state == EOI || (state == FRAME && data_valid_in) || (state == HUNT && enable_in && data_valid_in && soi);
      push_data = {state == EOI, held};
      push_cnt = state == HUNT ? 18'd1 : byte_cnt + 18'd1;
      // a push that would overflow the buffer or the frame length limit is dropped and kills the frame
      abort = want && ((full && !pop) || push_cnt > MAX_CNT);
      push = want && !abort;
      state_nxt = (abort || state == EOI) ? HUNT :
                  (state == HUNT && want) ? FRAME :
                  (state == FRAME && data_valid_in && held == 8'hFF && byte_in == 8'hD9) ? EOI : state;
   end
   always_ff @(posedge clk_in) begin
      if (rst_in) state <= HUNT;
      else state <= state_nxt;
   end
   always_ff @(posedge clk_in) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         held <= '0;
         held_v <= 1'b0;
         byte_cnt <= '0;
         pend_cnt <= '0;
         stall_cnt <= '0;
         out_idx <= '0;
         data_valid_out <= 1'b0;
         byte_out <= '0;
         complete_out <= 1'b0;
         frame_done_out <= 1'b0;
         frame_bytes_out <= '0;
         error_out <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            byte_cnt <= push_cnt;
         end
         if (push && state == EOI) pend_cnt <= push_cnt[16:0];
         if (abort) error_out <= 1'b1;
         if (((state == HUNT && enable_in) || state == FRAME) && data_valid_in) held <= byte_in;
         held_v <= (abort || state == EOI || (state == HUNT && !enable_in)) ? 1'b0 :
                   (state == HUNT && data_valid_in) ? 1'b1 : held_v;
         data_valid_out <= pop;
         complete_out <= pop && head[8];
         if (pop) byte_out <= head[7:0];
         frame_done_out <= complete_out;
         if (complete_out) frame_bytes_out <= pend_cnt;
         // out_idx wraps 3->0 on its own; the last byte of a frame also restarts the group
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            stall_cnt <= (out_idx == 2'd3 || head[8]) ? STALL : '0;
            out_idx <= head[8] ? 2'd0 : out_idx + 2'd1;
         end else if (stall_cnt != 8'd0) stall_cnt <= stall_cnt - 8'd1;
      end
   end
endmodule

// File: tb/tb_jpeg_frame_extractor.sv
// tb_jpeg_frame_extractor: directed checks of frame capture, pacing, abort and reset behaviour
module tb_jpeg_frame_extractor;
   logic clk_in = 1'b0;
   logic rst_in, enable_in, data_valid_in;
   logic [7:0] byte_in;
   logic data_valid_out, complete_out, frame_done_out, busy_out, error_out;
   logic [7:0] byte_out;
   logic [16:0] frame_bytes_out;
   logic s_valid, s_complete, s_done, s_busy, s_error;
   logic [7:0] s_byte;
   logic [16:0] s_fb;
   int compared = 0, mismatched = 0, cyc = 0;
   logic [7:0] got_b[$], stim[$], exp_b[$];
   logic got_c[$];
   int got_t[$], done_t[$];
   int s_n = 0, s_c = 0, busy_fall = 0, nc;
   bit busy_seen = 0, busy_q = 0;

   jpeg_frame_extractor dut (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .data_valid_in(data_valid_in),
      .byte_in(byte_in), .data_valid_out(data_valid_out), .byte_out(byte_out),
      .complete_out(complete_out), .frame_done_out(frame_done_out),
      .frame_bytes_out(frame_bytes_out), .busy_out(busy_out), .error_out(error_out)
   );
   jpeg_frame_extractor #(.MAX_FRAME_BYTES(8)) dut8 (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .data_valid_in(data_valid_in),
      .byte_in(byte_in), .data_valid_out(s_valid), .byte_out(s_byte),
      .complete_out(s_complete), .frame_done_out(s_done),
      .frame_bytes_out(s_fb), .busy_out(s_busy), .error_out(s_error)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   always @(negedge clk_in) begin
      if (data_valid_out) begin
         got_b.push_back(byte_out);
         got_c.push_back(complete_out);
         got_t.push_back(cyc);
      end
      if (frame_done_out) done_t.push_back(cyc);
      if (busy_out) busy_seen = 1'b1;
      if (busy_q && !busy_out) busy_fall = cyc;
      busy_q = busy_out;
      if (s_valid) s_n++;
      if (s_complete) s_c++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic play();
      foreach (stim[i]) begin
         @(negedge clk_in);
         data_valid_in = 1'b1;
         byte_in = stim[i];
      end
      @(negedge clk_in);
      data_valid_in = 1'b0;
      byte_in = 8'h00;
   endtask

   task automatic drain();
      int n = 0;
      while ((busy_out || s_busy) && n < 1000) begin
         @(negedge clk_in);
         n++;
      end
      check("drain_bound", n < 1000, 1);
      repeat (2) @(negedge clk_in);
   endtask

   task automatic clr();
      got_b.delete();
      got_c.delete();
      got_t.delete();
      done_t.delete();
      s_n = 0;
      s_c = 0;
      busy_seen = 1'b0;
   endtask

   task automatic expect_frame(input string tag, input int fb);
      check({tag, "_count"}, got_b.size(), exp_b.size());
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
         check({tag, "_byte"}, got_b[i], exp_b[i]);
         check({tag, "_complete"}, got_c[i], i == exp_b.size() - 1);
      end
      check({tag, "_frame_bytes"}, frame_bytes_out, fb);
      check({tag, "_done_pulses"}, done_t.size(), 1);
      if (done_t.size() == 1 && got_t.size() > 0)
         check({tag, "_done_timing"}, done_t[0], got_t[got_t.size() - 1] + 1);
   endtask

   initial begin
      rst_in = 1'b1;
      enable_in = 1'b0;
      data_valid_in = 1'b0;
      byte_in = 8'h00;
      repeat (3) @(negedge clk_in);
      check("reset_outputs", {data_valid_out, byte_out, complete_out, frame_done_out, frame_bytes_out, busy_out, error_out}, 0);
      rst_in = 1'b0;
      enable_in = 1'b1;
      clr();
      // basic capture with junk before and after the frame
      stim = '{8'h00, 8'hFF, 8'hD8, 8'h11, 8'h22, 8'hFF, 8'hD9, 8'h33};
      exp_b = '{8'hFF, 8'hD8, 8'h11, 8'h22, 8'hFF, 8'hD9};
      play();
      drain();
      expect_frame("t1", 6);
      check("t1_small_fb", s_fb, 6);
      check("t1_error", error_out, 0);
      // disarmed: frame ignored, then re-armed and captured
      clr();
      enable_in = 1'b0;
      stim = '{8'hFF, 8'hD8, 8'hAA, 8'hFF, 8'hD9};
      play();
      repeat (30) @(negedge clk_in);
      check("t3_off_count", got_b.size(), 0);
      check("t3_off_small_count", s_n, 0);
      check("t3_off_busy", busy_seen, 0);
      enable_in = 1'b1;
      clr();
      play();
      drain();
      exp_b = stim;
      expect_frame("t3", 5);
      check("t3_small_fb", s_fb, 5);
      // 12-byte frame: fine for the default unit, exceeds the 8-byte limit on the small one
      clr();
      stim = '{8'hFF, 8'hD8, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hFF, 8'hD9};
      exp_b = stim;
      play();
      drain();
      expect_frame("t5", 12);
      check("t5_small_error", s_error, 1);
      check("t5_small_complete", s_c, 0);
      check("t5_small_emitted", s_n, 8);
      check("t5_small_fb_kept", s_fb, 5);
      check("t5_error", error_out, 0);
      // pacing: groups of 4,4,2 with 5 idle cycles after each group
      clr();
      stim = '{8'hFF, 8'hD8, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hFF, 8'hD9};
      exp_b = stim;
      play();
      drain();
      expect_frame("t2", 10);
      if (got_t.size() == 10) begin
         for (int i = 1; i < 10; i++) check("t2_gap", got_t[i] - got_t[i-1], (i == 4 || i == 8) ? 6 : 1);
         check("t2_tail_stall", busy_fall - got_t[9], 5);
      end
      // overflow while stalled
      check("t4_error_before", error_out, 0);
      clr();
      stim.delete();
      stim.push_back(8'hFF);
      stim.push_back(8'hD8);
      for (int i = 0; i < 40; i++) stim.push_back(8'(8'h10 + i));
      stim.push_back(8'hFF);
      stim.push_back(8'hD9);
      play();
      drain();
      check("t4_error", error_out, 1);
      nc = 0;
      foreach (got_c[i]) nc += int'(got_c[i]);
      check("t4_no_complete", nc, 0);
      check("t4_drained_at_least_depth", got_b.size() >= 16, 1);
      check("t4_partial", got_b.size() < stim.size(), 1);
      for (int i = 0; i < got_b.size() && i < stim.size(); i++) check("t4_prefix", got_b[i], stim[i]);
      check("t4_fb_kept", frame_bytes_out, 10);
      clr();
      stim = '{8'hFF, 8'hD8, 8'h01, 8'h02, 8'hFF, 8'hD9};
      exp_b = stim;
      play();
      drain();
      expect_frame("t4_good", 6);
      // reset mid-frame with bytes queued
      clr();
      stim = '{8'hFF, 8'hD8, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      play();
      rst_in = 1'b1;
      check("t6_pre_count", got_b.size(), 4);
      check("t6_pre_busy", busy_out, 1);
      @(negedge clk_in);
      check("t6_reset_outputs", {data_valid_out, byte_out, complete_out, frame_done_out, frame_bytes_out, busy_out, error_out}, 0);
      check("t6_reset_small", {s_valid, s_byte, s_complete, s_done, s_fb, s_busy, s_error}, 0);
      rst_in = 1'b0;
      clr();
      stim = '{8'h09, 8'hFF, 8'hD9};
      play();
      repeat (20) @(negedge clk_in);
      check("t6_no_output", got_b.size(), 0);
      check("t6_idle_busy", busy_seen, 0);
      clr();
      stim = '{8'hFF, 8'hD8, 8'h77, 8'hFF, 8'hD9};
      exp_b = stim;
      play();
      drain();
      expect_frame("t6_new", 5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
